fifo_sync_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem_2p.sv | 26 ++
 rtl/fifo_sync_param.sv | 72 +++++++
 tb/tb_fifo_sync_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, width helpers and configuration check for fifo_sync_param
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit fifo_cfg_ok(input int depth, input int afull, input int aempty);
    return depth >= 2 && (depth & (depth - 1)) == 0 &&
           afull >= 0 && afull <= depth && aempty >= 0 && aempty <= depth;
  endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: WIDTH x DEPTH storage, sync write; registered read, or combinational under FIFO_FWFT_EN
module fifo_mem_2p #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
`ifdef FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
`endif
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with level flags and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  if (!fifo_cfg_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_cfg
    $error("fifo_sync_param: DEPTH must be a power of two >= 2 and thresholds within 0..DEPTH");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nx;
  logic rd_acc, wr_acc;
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
    count_nx = count + CW'(wr_acc) - CW'(rd_acc);
  end
  // flags follow the next-state count so they never lag count by a cycle
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= AFULL_THRESH == 0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_acc);
      rd_ptr <= rd_ptr + AW'(rd_acc);
      count <= count_nx;
      full <= count_nx == CW'(DEPTH);
      empty <= count_nx == '0;
      almost_full <= count_nx >= CW'(AFULL_THRESH);
      almost_empty <= count_nx <= CW'(AEMPTY_THRESH);
      overflow <= (wr_en && !wr_acc) || (overflow && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
`ifdef FIFO_FWFT_EN
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk) rd_valid <= !rst && rd_acc;
`endif
  fifo_mem_2p #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk), .rst(rst), .we(wr_acc), .waddr(wr_ptr), .wdata(wr_data),
    .re(rd_acc), .raddr(rd_ptr), .rdata(rd_data)
  );
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed and scoreboard checks of fifo_sync_param (DEPTH=16, WIDTH=8)
module tb_fifo_sync_param;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0, rd_data;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fifo_sync_param dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step(1, 8'h77, 1, 0);
    rst = 1'b0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset got count=%0d e=%b f=%b ae=%b af=%b v=%b ov=%b un=%b exp 0 1 0 1 0 0 0 0",
               count, empty, full, almost_empty, almost_full, rd_valid, overflow, underflow);
    end
`ifndef FIFO_FWFT_EN
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
`endif
    step(0, 0, 0, 0);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle got count=%0d e=%b v=%b exp 0 1 0", count, empty, rd_valid);
    end
  endtask
  task automatic test_fill_drain;
    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0, 0);
      checks++;
      if (count !== 5'(i) || full !== (i == 16) || almost_full !== (i >= 14) ||
          almost_empty !== (i <= 2) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d got count=%0d f=%b af=%b ae=%b e=%b exp count=%0d f=%b af=%b ae=%b e=0",
                 i, count, full, almost_full, almost_empty, empty, i, i == 16, i >= 14, i <= 2);
      end
    end
    step(1, 8'hAA, 0, 0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow got ov=%b count=%0d f=%b exp 1 16 1", overflow, count, full);
    end
    step(0, 0, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b exp 0", overflow); end
    step(1, 8'hBB, 1, 0);
    checks++;
    if (count !== 5'd16 || rd_valid !== 1'b1 || rd_data !== 8'h01 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_rw got count=%0d v=%b d=%h ov=%b f=%b exp 16 1 01 0 1",
               count, rd_valid, rd_data, overflow, full);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i < 15) ? 8'(i + 2) : 8'hBB;
      step(0, 0, 1, 0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp || count !== 5'(15 - i)) begin
        errors++;
        $display("FAIL drain_%0d got v=%b d=%h count=%0d exp 1 %h %0d", i, rd_valid, rd_data, count, exp, 15 - i);
      end
    end
    step(0, 0, 0, 0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hBB || empty !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL drained got v=%b d=%h e=%b un=%b exp 0 bb 1 0", rd_valid, rd_data, empty, underflow);
    end
  endtask
  task automatic test_underflow;
    step(0, 0, 1, 0);
    checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL underflow got un=%b v=%b count=%0d exp 1 0 0", underflow, rd_valid, count);
    end
    step(0, 0, 0, 1);
    checks++;
    if (underflow !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_err got un=%b ov=%b exp 0 0", underflow, overflow);
    end
    step(1, 8'h33, 1, 0);
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw got count=%0d un=%b v=%b e=%b exp 1 1 0 0", count, underflow, rd_valid, empty);
    end
    step(0, 0, 1, 1);
    checks++;
    if (rd_data !== 8'h33 || rd_valid !== 1'b1 || underflow !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL empty_rw_pop got d=%h v=%b un=%b count=%0d exp 33 1 0 0", rd_data, rd_valid, underflow, count);
    end
  endtask
  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] exp_d, d;
    logic w, r, racc, wacc;
    int n;
    for (int c = 0; c < 200; c++) begin
      w = $urandom_range(99) < ((c < 100) ? 70 : 30);
      r = $urandom_range(99) < ((c < 100) ? 30 : 70);
      d = 8'($urandom);
      racc = r && q.size() > 0;
      wacc = w && (q.size() < 16 || racc);
      exp_d = 8'h00;
      if (racc) exp_d = q.pop_front();
      if (wacc) q.push_back(d);
      step(w, d, r, 0);
      n = q.size();
      if (racc) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
          errors++;
          $display("FAIL rand_data_%0d got v=%b d=%h exp 1 %h", c, rd_valid, rd_data, exp_d);
        end
      end
      checks++;
      if (count !== 5'(n) || full !== (n == 16) || empty !== (n == 0) ||
          almost_full !== (n >= 14) || almost_empty !== (n <= 2) || rd_valid !== racc) begin
        errors++;
        $display("FAIL rand_state_%0d got count=%0d f=%b e=%b af=%b ae=%b v=%b exp %0d %b %b %b %b %b",
                 c, count, full, empty, almost_full, almost_empty, rd_valid,
                 n, n == 16, n == 0, n >= 14, n <= 2, racc);
      end
    end
  endtask
  task automatic test_fwft;
    step(1, 8'h5A, 0, 0);
    checks++;
    if (rd_data !== 8'h5A || rd_valid !== 1'b1 || count !== 5'd1) begin
      errors++;
      $display("FAIL fwft_show got d=%h v=%b count=%0d exp 5a 1 1", rd_data, rd_valid, count);
    end
    step(0, 0, 1, 0);
    checks++;
    if (empty !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL fwft_pop got e=%b v=%b count=%0d exp 1 0 0", empty, rd_valid, count);
    end
    for (int i = 0; i < 7; i++) step(1, 8'(8'h60 + i), 0, 0);
    checks++;
    if (count !== 5'd7 || rd_data !== 8'h60) begin
      errors++;
      $display("FAIL fwft_fill got count=%0d d=%h exp 7 60", count, rd_data);
    end
    rst = 1'b1;
    step(1, 8'hEE, 1, 0);
    rst = 1'b0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwft_rst got count=%0d e=%b v=%b exp 0 1 0", count, empty, rd_valid);
    end
  endtask
  initial begin
    test_reset;
`ifdef FIFO_FWFT_EN
    test_fwft;
`else
    test_fill_drain;
    test_underflow;
    test_random;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
